// File: rtl/fir_ctrl.sv
// fir_ctrl - sequencing controller for the bit-serial symmetric FIR.
//
// Holds a shadow coefficient bank written over a register port and, on
// commit, shifts it MSB-first (coefficient NCoeffs-1 first, coefficient 0
// last) into the FIR coefficient chain. Samples arrive on a valid/ready
// handshake; each accepted sample gets one fir_start pulse. The result
// returned with fir_done lands in a one-entry output buffer. A result that
// overwrites an unread one is counted in drop_cnt.
//
// Optional feature: define FIR_CTRL_WATCHDOG_EN to enable a watchdog that
// abandons a RUN without fir_done after WdogCycles and sets the sticky fault.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data      shadow coefficient write port
//   cfg_sym, cfg_commit, cfg_busy symmetry select, load request, busy flag
//   in_valid/in_ready/in_data     sample input handshake
//   out_valid/out_ready/out_data  filtered output handshake
//   drop_cnt, fault               saturating drop counter, watchdog fault
//   fir_start, fir_coeff_load, fir_coeff_in, fir_sym, fir_lock, fir_x
//                                 controls to the FIR
//   fir_done, fir_y               FIR completion pulse and result
//
// state  | meaning
// IDLE   | waiting for a commit (priority) or an input sample
// LOAD   | streaming the snapshotted bank into the FIR, one bit per cycle
// SETTLE | one cycle with coeff_load low so the FIR returns to idle
// RUN    | sample issued, waiting for fir_done
module fir_ctrl #(
  parameter int DataWidth  = 12,
  parameter int NCoeffs    = 5,
  parameter int WdogCycles = 2 * NCoeffs * DataWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(NCoeffs)-1:0] cfg_addr,
  input  logic [DataWidth-1:0]       cfg_data,
  input  logic                       cfg_sym,
  input  logic                       cfg_commit,
  output logic                       cfg_busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DataWidth-1:0]       in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DataWidth-1:0]       out_data,
  output logic [7:0]                 drop_cnt,
  output logic                       fault,
  output logic                       fir_start,
  output logic                       fir_coeff_load,
  output logic                       fir_coeff_in,
  output logic                       fir_sym,
  output logic                       fir_lock,
  output logic [DataWidth-1:0]       fir_x,
  input  logic                       fir_done,
  input  logic [DataWidth-1:0]       fir_y
);

  localparam int LoadBits = NCoeffs * DataWidth;
  localparam int LoadCntW = $clog2(LoadBits);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

  state_t                state;
  logic [DataWidth-1:0]  bank [NCoeffs];
  logic [LoadBits-1:0]   bank_flat;
  logic [LoadBits-1:0]   load_sreg;
  logic [LoadCntW-1:0]   load_cnt;
  logic                  commit_pending;

`ifdef FIR_CTRL_WATCHDOG_EN
  localparam int WdogW = $clog2(WdogCycles + 1);
  logic [WdogW-1:0] wdog_cnt;
  logic             fault_q;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Coefficient NCoeffs-1 sits in the top bits so it leaves first.
  always_comb begin
    bank_flat = '0;
    for (int i = 0; i < NCoeffs; i++) begin
      bank_flat[i*DataWidth +: DataWidth] = bank[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCoeffs; i++) begin
        bank[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_addr) < NCoeffs)) begin
      bank[cfg_addr] <= cfg_data;
    end
  end

  // A commit presented in IDLE wins over a sample in the same cycle.
  assign in_ready = !rst && (state == IDLE) && !commit_pending && !cfg_commit;
  assign cfg_busy = commit_pending || (state == LOAD) || (state == SETTLE);
  assign fir_lock = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      load_sreg      <= '0;
      load_cnt       <= '0;
      fir_start      <= 1'b0;
      fir_coeff_load <= 1'b0;
      fir_coeff_in   <= 1'b0;
      fir_sym        <= 1'b1;
      fir_x          <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      drop_cnt       <= '0;
`ifdef FIR_CTRL_WATCHDOG_EN
      wdog_cnt       <= '0;
      fault_q        <= 1'b0;
`endif
    end else begin
      fir_start <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (cfg_commit && (state != IDLE)) begin
        commit_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (commit_pending || cfg_commit) begin
            state          <= LOAD;
            commit_pending <= 1'b0;
            fir_sym        <= cfg_sym;
            load_sreg      <= bank_flat;
            load_cnt       <= LoadCntW'(LoadBits - 1);
            fir_coeff_load <= 1'b1;
            fir_coeff_in   <= bank_flat[LoadBits-1];
          end else if (in_valid) begin
            fir_x     <= in_data;
            fir_start <= 1'b1;
            state     <= RUN;
`ifdef FIR_CTRL_WATCHDOG_EN
            wdog_cnt  <= WdogW'(WdogCycles - 1);
`endif
          end
        end

        LOAD: begin
          if (load_cnt == '0) begin
            state          <= SETTLE;
            fir_coeff_load <= 1'b0;
            fir_coeff_in   <= 1'b0;
          end else begin
            load_cnt     <= load_cnt - LoadCntW'(1);
            load_sreg    <= {load_sreg[LoadBits-2:0], 1'b0};
            fir_coeff_in <= load_sreg[LoadBits-2];
          end
        end

        SETTLE: begin
          state <= IDLE;
        end

        RUN: begin
          if (fir_done) begin
            out_data  <= fir_y;
            out_valid <= 1'b1;
            if (out_valid && !out_ready && (drop_cnt != 8'hFF)) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
            state <= IDLE;
          end
`ifdef FIR_CTRL_WATCHDOG_EN
          else if (wdog_cnt == '0) begin
            // Abandon the sample; the output buffer is left untouched.
            fault_q <= 1'b1;
            state   <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt - WdogW'(1);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
